// File: rtl/l2_request_arbiter.sv
// l2_request_arbiter: L2 pipeline front end; each unstalled cycle grants at most one of
// the restart port or the two core request ports and registers it into the tag-stage input.
// Ports:
//   clk, reset (async, active-high), stall_pipeline (freezes all state, masks acks)
//   core0_l2req_* / core1_l2req_*  : core requests in, *_ack out (combinational)
//   sm_restart_*                   : restarted request with fill data in, sm_restart_ack out
//   arb_l2req_*, arb_has_sm_data, arb_sm_data, arb_sm_fill_l2_way : registered grant to tag stage
// Optional: define L2_ARB_ANTI_STARVE_EN to let a core that has waited STARVE_LIMIT
// unstalled cycles override the restart port.
module l2_request_arbiter #(
   parameter int unsigned STARVE_LIMIT     = 8,
   parameter int unsigned STARVE_CNT_WIDTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         stall_pipeline,
   input  logic         core0_l2req_valid,
   input  logic [1:0]   core0_l2req_unit,
   input  logic [1:0]   core0_l2req_strand,
   input  logic [2:0]   core0_l2req_op,
   input  logic [1:0]   core0_l2req_way,
   input  logic [25:0]  core0_l2req_address,
   input  logic [511:0] core0_l2req_data,
   input  logic [63:0]  core0_l2req_mask,
   output logic         core0_l2req_ack,
   input  logic         core1_l2req_valid,
   input  logic [1:0]   core1_l2req_unit,
   input  logic [1:0]   core1_l2req_strand,
   input  logic [2:0]   core1_l2req_op,
   input  logic [1:0]   core1_l2req_way,
   input  logic [25:0]  core1_l2req_address,
   input  logic [511:0] core1_l2req_data,
   input  logic [63:0]  core1_l2req_mask,
   output logic         core1_l2req_ack,
   input  logic         sm_restart_valid,
   input  logic [1:0]   sm_restart_core,
   input  logic [1:0]   sm_restart_unit,
   input  logic [1:0]   sm_restart_strand,
   input  logic [2:0]   sm_restart_op,
   input  logic [1:0]   sm_restart_way,
   input  logic [25:0]  sm_restart_address,
   input  logic [511:0] sm_restart_data,
   input  logic [63:0]  sm_restart_mask,
   input  logic [511:0] sm_restart_sm_data,
   input  logic [1:0]   sm_restart_fill_way,
   output logic         sm_restart_ack,
   output logic         arb_l2req_valid,
   output logic [1:0]   arb_l2req_core,
   output logic [1:0]   arb_l2req_unit,
   output logic [1:0]   arb_l2req_strand,
   output logic [2:0]   arb_l2req_op,
   output logic [1:0]   arb_l2req_way,
   output logic [25:0]  arb_l2req_address,
   output logic [511:0] arb_l2req_data,
   output logic [63:0]  arb_l2req_mask,
   output logic         arb_has_sm_data,
   output logic [511:0] arb_sm_data,
   output logic [1:0]   arb_sm_fill_l2_way
);
   typedef struct packed {
      logic         valid;
      logic [1:0]   core;
      logic [1:0]   unit;
      logic [1:0]   strand;
      logic [2:0]   op;
      logic [1:0]   way;
      logic [25:0]  address;
      logic [511:0] data;
      logic [63:0]  mask;
      logic         has_sm_data;
      logic [511:0] sm_data;
      logic [1:0]   fill_way;
   } arb_out_t;

   arb_out_t out_q, out_d;
   logic     last_core_q, last_core_d;
   logic     starve0, starve1, any_starve, core_win, pick_c1, go;
   logic     gnt_sm, gnt_c0, gnt_c1;

`ifdef L2_ARB_ANTI_STARVE_EN
   localparam logic [STARVE_CNT_WIDTH-1:0] LIMIT = STARVE_CNT_WIDTH'(STARVE_LIMIT);
   logic [STARVE_CNT_WIDTH-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
   assign starve0 = core0_l2req_valid && cnt0_q == LIMIT;
   assign starve1 = core1_l2req_valid && cnt1_q == LIMIT;
   // Count unstalled cycles spent waiting; a grant or a dropped request restarts the count.
   always_comb begin
      cnt0_d = stall_pipeline ? cnt0_q : (!core0_l2req_valid || gnt_c0) ? '0 :
               (cnt0_q == LIMIT) ? cnt0_q : cnt0_q + 1'b1;
      cnt1_d = stall_pipeline ? cnt1_q : (!core1_l2req_valid || gnt_c1) ? '0 :
               (cnt1_q == LIMIT) ? cnt1_q : cnt1_q + 1'b1;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
`else
   logic unused_starve;
   assign unused_starve = |{STARVE_LIMIT, STARVE_CNT_WIDTH};
   assign starve0 = 1'b0;
   assign starve1 = 1'b0;
`endif

   // A starved core outranks the restart port; otherwise restart first, then cores round-robin.
   assign go         = !stall_pipeline && !reset;
   assign any_starve = starve0 | starve1;
   assign pick_c1    = any_starve ? ((starve0 & starve1) ? !last_core_q : starve1)
                                  : ((core0_l2req_valid & core1_l2req_valid) ? !last_core_q : core1_l2req_valid);
   assign core_win   = any_starve || (!sm_restart_valid && (core0_l2req_valid || core1_l2req_valid));
   assign gnt_sm     = go && sm_restart_valid && !any_starve;
   assign gnt_c0     = go && core_win && !pick_c1;
   assign gnt_c1     = go && core_win && pick_c1;

   assign core0_l2req_ack = gnt_c0;
   assign core1_l2req_ack = gnt_c1;
   assign sm_restart_ack  = gnt_sm;

   always_comb begin
      out_d       = out_q;
      last_core_d = last_core_q;
      if (!stall_pipeline) begin
         out_d.valid = gnt_sm | gnt_c0 | gnt_c1;
         if (gnt_sm)
            out_d = {1'b1, sm_restart_core, sm_restart_unit, sm_restart_strand, sm_restart_op,
                     sm_restart_way, sm_restart_address, sm_restart_data, sm_restart_mask,
                     1'b1, sm_restart_sm_data, sm_restart_fill_way};
         else if (gnt_c0 | gnt_c1) begin
            out_d = pick_c1
               ? {1'b1, 2'd1, core1_l2req_unit, core1_l2req_strand, core1_l2req_op, core1_l2req_way,
                  core1_l2req_address, core1_l2req_data, core1_l2req_mask, 1'b0, 512'd0, 2'd0}
               : {1'b1, 2'd0, core0_l2req_unit, core0_l2req_strand, core0_l2req_op, core0_l2req_way,
                  core0_l2req_address, core0_l2req_data, core0_l2req_mask, 1'b0, 512'd0, 2'd0};
            last_core_d = pick_c1;
         end
      end
   end

   // last_core resets to 1 so core0 is preferred first.
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         out_q       <= '0;
         last_core_q <= 1'b1;
      end else begin
         out_q       <= out_d;
         last_core_q <= last_core_d;
      end

   assign arb_l2req_valid    = out_q.valid;
   assign arb_l2req_core     = out_q.core;
   assign arb_l2req_unit     = out_q.unit;
   assign arb_l2req_strand   = out_q.strand;
   assign arb_l2req_op       = out_q.op;
   assign arb_l2req_way      = out_q.way;
   assign arb_l2req_address  = out_q.address;
   assign arb_l2req_data     = out_q.data;
   assign arb_l2req_mask     = out_q.mask;
   assign arb_has_sm_data    = out_q.has_sm_data;
   assign arb_sm_data        = out_q.sm_data;
   assign arb_sm_fill_l2_way = out_q.fill_way;
endmodule

// File: tb/tb_l2_request_arbiter.sv
// tb_l2_request_arbiter: directed table, corner sequences and randomized model check of l2_request_arbiter.
module tb_l2_request_arbiter;
   localparam int LIMIT = 8;
`ifdef L2_ARB_ANTI_STARVE_EN
   localparam bit STARVE = 1'b1;
`else
   localparam bit STARVE = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset, stall_pipeline;
   logic         cv[2];
   logic [1:0]   cunit[2], cstrand[2], cway[2];
   logic [2:0]   cop[2];
   logic [25:0]  caddr[2];
   logic [511:0] cdata[2];
   logic [63:0]  cmask[2];
   logic         cack0, cack1;
   logic         smv, smack;
   logic [1:0]   smcore, smunit, smstrand, smway, smfill;
   logic [2:0]   smop;
   logic [25:0]  smaddr;
   logic [511:0] smdata, smsm;
   logic [63:0]  smmask;
   logic         ov, ohas;
   logic [1:0]   ocore, ounit, ostrand, oway, ofill;
   logic [2:0]   oop;
   logic [25:0]  oaddr;
   logic [511:0] odata, osm;
   logic [63:0]  omask;

   l2_request_arbiter dut (
      .clk(clk), .reset(reset), .stall_pipeline(stall_pipeline),
      .core0_l2req_valid(cv[0]), .core0_l2req_unit(cunit[0]), .core0_l2req_strand(cstrand[0]),
      .core0_l2req_op(cop[0]), .core0_l2req_way(cway[0]), .core0_l2req_address(caddr[0]),
      .core0_l2req_data(cdata[0]), .core0_l2req_mask(cmask[0]), .core0_l2req_ack(cack0),
      .core1_l2req_valid(cv[1]), .core1_l2req_unit(cunit[1]), .core1_l2req_strand(cstrand[1]),
      .core1_l2req_op(cop[1]), .core1_l2req_way(cway[1]), .core1_l2req_address(caddr[1]),
      .core1_l2req_data(cdata[1]), .core1_l2req_mask(cmask[1]), .core1_l2req_ack(cack1),
      .sm_restart_valid(smv), .sm_restart_core(smcore), .sm_restart_unit(smunit),
      .sm_restart_strand(smstrand), .sm_restart_op(smop), .sm_restart_way(smway),
      .sm_restart_address(smaddr), .sm_restart_data(smdata), .sm_restart_mask(smmask),
      .sm_restart_sm_data(smsm), .sm_restart_fill_way(smfill), .sm_restart_ack(smack),
      .arb_l2req_valid(ov), .arb_l2req_core(ocore), .arb_l2req_unit(ounit),
      .arb_l2req_strand(ostrand), .arb_l2req_op(oop), .arb_l2req_way(oway),
      .arb_l2req_address(oaddr), .arb_l2req_data(odata), .arb_l2req_mask(omask),
      .arb_has_sm_data(ohas), .arb_sm_data(osm), .arb_sm_fill_l2_way(ofill)
   );

   int errors = 0, checks = 0;

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Directed rows: inputs {c0,c1,sm,stall}, expected acks {a0,a1,asm}, then registered valid/core/has_sm.
   typedef struct packed {
      logic c0, c1, sm, st, a0, a1, as, ov;
      logic [1:0] core;
      logic has, chkf;
   } vec_t;
   vec_t tbl[18];

   typedef struct {
      logic v, has;
      logic [1:0] core, unit, strand, way, fill;
      logic [2:0] op;
      logic [25:0] addr;
      logic [511:0] data, smd;
      logic [63:0] mask;
   } out_t;
   out_t exp_o;
   int last_c, cnt[2], w;

   function automatic logic [511:0] r512();
      logic [511:0] r;
      for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   // Reference: starved cores first, then restart, then round-robin between valid cores.
   function automatic int pick();
      bit s0, s1;
      if (stall_pipeline) return -1;
      s0 = STARVE && cv[0] && cnt[0] == LIMIT;
      s1 = STARVE && cv[1] && cnt[1] == LIMIT;
      if (s0 && s1) return 1 - last_c;
      if (s0) return 0;
      if (s1) return 1;
      if (smv) return 2;
      if (cv[0] && cv[1]) return 1 - last_c;
      if (cv[0]) return 0;
      if (cv[1]) return 1;
      return -1;
   endfunction

   task automatic model_clock();
      if (!stall_pipeline) begin
         if (w == 2) begin
            exp_o.core = smcore; exp_o.unit = smunit; exp_o.strand = smstrand; exp_o.op = smop;
            exp_o.way = smway; exp_o.addr = smaddr; exp_o.data = smdata; exp_o.mask = smmask;
            exp_o.has = 1'b1; exp_o.smd = smsm; exp_o.fill = smfill;
         end else if (w >= 0) begin
            exp_o.core = 2'(w); exp_o.unit = cunit[w]; exp_o.strand = cstrand[w]; exp_o.op = cop[w];
            exp_o.way = cway[w]; exp_o.addr = caddr[w]; exp_o.data = cdata[w]; exp_o.mask = cmask[w];
            exp_o.has = 1'b0; exp_o.smd = '0; exp_o.fill = 2'd0;
            last_c = w;
         end
         exp_o.v = (w >= 0);
         for (int i = 0; i < 2; i++)
            cnt[i] = (!cv[i] || w == i) ? 0 : (cnt[i] < LIMIT ? cnt[i] + 1 : cnt[i]);
      end
   endtask

   task automatic cmp_out();
      chk("out valid", ov, exp_o.v);
      if (exp_o.v) begin
         chk("out core", ocore, exp_o.core);     chk("out unit", ounit, exp_o.unit);
         chk("out strand", ostrand, exp_o.strand); chk("out op", oop, exp_o.op);
         chk("out way", oway, exp_o.way);        chk("out addr", oaddr, exp_o.addr);
         chk("out data", odata, exp_o.data);     chk("out mask", omask, exp_o.mask);
         chk("out has_sm", ohas, exp_o.has);     chk("out sm_data", osm, exp_o.smd);
         chk("out fill", ofill, exp_o.fill);
      end
   endtask

   task automatic new_core(input int i);
      cunit[i] = 2'($urandom); cstrand[i] = 2'($urandom); cop[i] = 3'($urandom);
      cway[i] = 2'($urandom); caddr[i] = 26'($urandom); cdata[i] = r512();
      cmask[i] = {$urandom, $urandom};
   endtask

   task automatic new_sm();
      smcore = 2'($urandom); smunit = 2'($urandom); smstrand = 2'($urandom); smop = 3'($urandom);
      smway = 2'($urandom); smaddr = 26'($urandom); smdata = r512(); smmask = {$urandom, $urandom};
      smsm = r512(); smfill = 2'($urandom);
   endtask

   initial begin
      tbl[0]  = 12'b1100_100_1_00_0_1;
      tbl[1]  = 12'b1100_010_1_01_0_1;
      tbl[2]  = 12'b1100_100_1_00_0_1;
      tbl[3]  = 12'b1100_010_1_01_0_1;
      tbl[4]  = 12'b1010_001_1_10_1_1;
      tbl[5]  = 12'b1000_100_1_00_0_1;
      tbl[6]  = 12'b0101_000_1_00_0_1;
      tbl[7]  = 12'b0101_000_1_00_0_1;
      tbl[8]  = 12'b0101_000_1_00_0_1;
      tbl[9]  = 12'b0100_010_1_01_0_1;
      tbl[10] = 12'b0000_000_0_00_0_0;
      tbl[11] = 12'b1000_100_1_00_0_1;
      tbl[12] = 12'b1000_100_1_00_0_1;
      tbl[13] = 12'b1100_010_1_01_0_1;
      tbl[14] = 12'b1011_000_1_01_0_1;
      tbl[15] = 12'b1010_001_1_10_1_1;
      tbl[16] = 12'b1000_100_1_00_0_1;
      tbl[17] = 12'b0000_000_0_00_0_0;

      for (int i = 0; i < 2; i++) begin
         cunit[i] = '0; cstrand[i] = '0; cop[i] = 3'd0; cway[i] = '0; cdata[i] = '0; cmask[i] = '0;
      end
      caddr[0] = 26'h0000123; caddr[1] = 26'h0000456;
      smcore = 2'd2; smunit = '0; smstrand = '0; smop = 3'd1; smway = '0; smaddr = 26'h0000789;
      smdata = '0; smmask = '0; smsm = {16{32'hA5A5_5A5A}}; smfill = 2'd2;

      // Reset with everything requesting: no acks, outputs cleared.
      reset = 1'b1; stall_pipeline = 1'b0; cv[0] = 1'b1; cv[1] = 1'b1; smv = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      chk("reset valid", ov, 1'b0); chk("reset core", ocore, 2'd0); chk("reset has_sm", ohas, 1'b0);
      chk("reset fill", ofill, 2'd0);
      chk("reset ack0", cack0, 1'b0); chk("reset ack1", cack1, 1'b0); chk("reset smack", smack, 1'b0);
      @(negedge clk); reset = 1'b0;

      for (int i = 0; i < 18; i++) begin
         cv[0] = tbl[i].c0; cv[1] = tbl[i].c1; smv = tbl[i].sm; stall_pipeline = tbl[i].st;
         #1;
         chk($sformatf("row%0d ack0", i), cack0, tbl[i].a0);
         chk($sformatf("row%0d ack1", i), cack1, tbl[i].a1);
         chk($sformatf("row%0d smack", i), smack, tbl[i].as);
         @(posedge clk); #1;
         chk($sformatf("row%0d valid", i), ov, tbl[i].ov);
         if (tbl[i].chkf) begin
            chk($sformatf("row%0d core", i), ocore, tbl[i].core);
            chk($sformatf("row%0d has_sm", i), ohas, tbl[i].has);
            chk($sformatf("row%0d fill", i), ofill, tbl[i].has ? 2'd2 : 2'd0);
            chk($sformatf("row%0d addr", i), oaddr,
                tbl[i].has ? 26'h0000789 : (tbl[i].core == 2'd1 ? 26'h0000456 : 26'h0000123));
         end
         @(negedge clk);
      end

      // Restart held every cycle against a waiting core0.
      cv[0] = 1'b1; cv[1] = 1'b0; smv = 1'b1; stall_pipeline = 1'b0;
      for (int i = 0; i < 12; i++) begin
         #1;
         chk($sformatf("starve%0d ack0", i), cack0, STARVE && i == LIMIT);
         chk($sformatf("starve%0d smack", i), smack, !(STARVE && i == LIMIT));
         @(posedge clk); @(negedge clk);
      end

      // Reset asserted while output is valid.
      smv = 1'b0; #1;
      chk("pre-reset ack0", cack0, 1'b1);
      @(posedge clk); #1;
      chk("pre-reset valid", ov, 1'b1);
      cv[1] = 1'b1; #1; reset = 1'b1; #1;
      chk("midreset valid", ov, 1'b0); chk("midreset ack0", cack0, 1'b0); chk("midreset ack1", cack1, 1'b0);
      @(negedge clk); @(negedge clk); reset = 1'b0; #1;
      chk("post-reset ack0", cack0, 1'b1); chk("post-reset ack1", cack1, 1'b0);
      @(posedge clk); #1;
      chk("post-reset core", ocore, 2'd0); chk("post-reset valid", ov, 1'b1);
      @(negedge clk);

      // Randomized run against the reference model.
      reset = 1'b1; cv[0] = 1'b0; cv[1] = 1'b0; smv = 1'b0;
      @(negedge clk); reset = 1'b0;
      last_c = 1; cnt[0] = 0; cnt[1] = 0; exp_o.v = 1'b0; w = -1;
      #1 cmp_out();
      for (int n = 0; n < 2000; n++) begin
         for (int i = 0; i < 2; i++)
            if (!cv[i] || w == i) begin cv[i] = ($urandom % 3) != 0; new_core(i); end
         if (!smv || w == 2) begin smv = ($urandom % 2) != 0; new_sm(); end
         stall_pipeline = ($urandom % 5) == 0;
         #1;
         w = pick();
         chk("rand ack0", cack0, w == 0);
         chk("rand ack1", cack1, w == 1);
         chk("rand smack", smack, w == 2);
         @(posedge clk);
         model_clock();
         #1 cmp_out();
         @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
